// File: rtl/counter_run_ctrl.sv
// Run/stop/clear controller for the 0..COUNT_MAX display counter.
// A divider paces count ticks while running; the FSM is steered by one-cycle button pulses.
module counter_run_ctrl #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int COUNT_MAX = 9_999,
  parameter int CNT_W     = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_run_stop,
  input  logic             btn_clear,
  input  logic             sw_mode,
  output logic [CNT_W-1:0] count_data,
  output logic             o_tick,
  output logic             o_run,
  output logic [1:0]       o_state
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] divider_reg, divider_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             tick_reg, tick_next;
  logic             run_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_STOP;
      divider_reg <= '0;
      count_reg   <= '0;
      tick_reg    <= 1'b0;
      run_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      divider_reg <= divider_next;
      count_reg   <= count_next;
      tick_reg    <= tick_next;
      run_reg     <= (state_next == ST_RUN);
    end
  end

  always_comb begin
    state_next   = state_reg;
    divider_next = divider_reg;
    count_next   = count_reg;
    tick_next    = 1'b0;
    case (state_reg)
      ST_STOP: begin
        if (btn_clear) begin
          state_next = ST_CLEAR;
        end else if (btn_run_stop) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // A stop pulse coinciding with a wrap still applies that tick.
        if (btn_run_stop) begin
          state_next = ST_STOP;
        end
        if (divider_reg == DIV_LAST) begin
          divider_next = '0;
          tick_next    = 1'b1;
          if (sw_mode) begin
            count_next = (count_reg == '0) ? CNT_LAST : count_reg - 1'b1;
          end else begin
            count_next = (count_reg == CNT_LAST) ? '0 : count_reg + 1'b1;
          end
        end else begin
          divider_next = divider_reg + 1'b1;
        end
      end
      ST_CLEAR: begin
        state_next   = ST_STOP;
        divider_next = '0;
        count_next   = '0;
      end
      default: begin
        state_next = ST_STOP;
      end
    endcase
  end

  assign count_data = count_reg;
  assign o_tick     = tick_reg;
  assign o_run      = run_reg;
  assign o_state    = state_reg;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Self-checking bench for counter_run_ctrl with TICK_DIV=4: per-cycle stimulus table
// with hand-derived expected outputs, queued on drive and compared after the edge.
module tb_counter_run_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int COUNT_MAX = 9999;
  localparam int CNT_W     = 14;

  logic             clk = 1'b0;
  logic             reset;
  logic             btn_run_stop;
  logic             btn_clear;
  logic             sw_mode;
  logic [CNT_W-1:0] count_data;
  logic             o_tick;
  logic             o_run;
  logic [1:0]       o_state;

  counter_run_ctrl #(
    .TICK_DIV (TICK_DIV),
    .COUNT_MAX(COUNT_MAX),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_run_stop(btn_run_stop),
    .btn_clear   (btn_clear),
    .sw_mode     (sw_mode),
    .count_data  (count_data),
    .o_tick      (o_tick),
    .o_run       (o_run),
    .o_state     (o_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rs;
    logic        clr;
    logic        mode;
    int unsigned count;
    logic        tick;
    logic        run;
    logic [1:0]  state;
  } vec_t;

  typedef struct {
    int unsigned count;
    logic        tick;
    logic        run;
    logic [1:0]  state;
    int          id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic rs, input logic clr, input logic mode,
                     input int unsigned cnt, input logic tk, input logic run,
                     input logic [1:0] st);
    vec_t v;
    v.rs = rs; v.clr = clr; v.mode = mode;
    v.count = cnt; v.tick = tk; v.run = run; v.state = st;
    vecs.push_back(v);
  endtask

  task automatic rep(input int n, input logic rs, input logic clr, input logic mode,
                     input int unsigned cnt, input logic tk, input logic run,
                     input logic [1:0] st);
    for (int i = 0; i < n; i++) add(rs, clr, mode, cnt, tk, run, st);
  endtask

  task automatic compare(input string name, input int id, input exp_t e);
    logic [CNT_W-1:0] ec;
    ec = e.count[CNT_W-1:0];
    checks++;
    if (count_data !== ec || o_tick !== e.tick || o_run !== e.run || o_state !== e.state) begin
      errors++;
      $display("FAIL %s #%0d: got count=%0d tick=%0b run=%0b state=%b, expected count=%0d tick=%0b run=%0b state=%b",
               name, id, count_data, o_tick, o_run, o_state, e.count, e.tick, e.run, e.state);
    end else begin
      $display("ok   %s #%0d: count=%0d tick=%0b run=%0b state=%b",
               name, id, count_data, o_tick, o_run, o_state);
    end
  endtask

  task automatic check_now(input string name, input int unsigned cnt, input logic tk,
                           input logic run, input logic [1:0] st);
    exp_t e;
    e.count = cnt; e.tick = tk; e.run = run; e.state = st; e.id = 0;
    compare(name, 0, e);
  endtask

  // Drive one cycle of stimulus, queue its expectation, then check after the edge.
  task automatic step(input string name, input vec_t v, input int id);
    exp_t e;
    btn_run_stop = v.rs;
    btn_clear    = v.clr;
    sw_mode      = v.mode;
    e.count = v.count; e.tick = v.tick; e.run = v.run; e.state = v.state; e.id = id;
    sb.push_back(e);
    @(posedge clk);
    #1;
    btn_run_stop = 1'b0;
    btn_clear    = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s #%0d: scoreboard empty, got count=%0d, expected an entry", name, id, count_data);
    end else begin
      e = sb.pop_front();
      compare(name, e.id, e);
    end
  endtask

  initial begin
    vec_t idle;
    // Count up 1,2,3 with a tick every 4 clocks.
    add(1, 0, 0, 0, 0, 1, 2'b01);
    rep(3, 0, 0, 0, 0, 0, 1, 2'b01);
    add(0, 0, 0, 1, 1, 1, 2'b01);
    rep(3, 0, 0, 0, 1, 0, 1, 2'b01);
    add(0, 0, 0, 2, 1, 1, 2'b01);
    rep(3, 0, 0, 0, 2, 0, 1, 2'b01);
    add(0, 0, 0, 3, 1, 1, 2'b01);
    // Stop 2 clocks into a period, idle 20, resume: tick 2 clocks later.
    add(0, 0, 0, 3, 0, 1, 2'b01);
    add(1, 0, 0, 3, 0, 0, 2'b00);
    rep(20, 0, 0, 0, 3, 0, 0, 2'b00);
    add(1, 0, 0, 3, 0, 1, 2'b01);
    add(0, 0, 0, 3, 0, 1, 2'b01);
    add(0, 0, 0, 4, 1, 1, 2'b01);
    // Stop pulse on the wrap edge: tick applied and state goes STOP.
    rep(3, 0, 0, 0, 4, 0, 1, 2'b01);
    add(1, 0, 0, 5, 1, 0, 2'b00);
    add(0, 0, 0, 5, 0, 0, 2'b00);
    // Both buttons in STOP: clear wins; pulses during CLEAR ignored.
    add(1, 1, 0, 5, 0, 0, 2'b10);
    add(1, 0, 0, 0, 0, 0, 2'b00);
    add(0, 0, 0, 0, 0, 0, 2'b00);
    // Clear pulses in RUN are ignored.
    add(1, 0, 0, 0, 0, 1, 2'b01);
    add(0, 1, 0, 0, 0, 1, 2'b01);
    add(0, 0, 0, 0, 0, 1, 2'b01);
    add(0, 1, 0, 0, 0, 1, 2'b01);
    add(0, 1, 0, 1, 1, 1, 2'b01);
    // Down across zero: 0, 9999, 9998.
    rep(3, 0, 0, 1, 1, 0, 1, 2'b01);
    add(0, 0, 1, 0, 1, 1, 2'b01);
    rep(3, 0, 0, 1, 0, 0, 1, 2'b01);
    add(0, 0, 1, 9999, 1, 1, 2'b01);
    rep(3, 0, 0, 1, 9999, 0, 1, 2'b01);
    add(0, 0, 1, 9998, 1, 1, 2'b01);
    // Up across the top: 9999, 0.
    rep(3, 0, 0, 0, 9998, 0, 1, 2'b01);
    add(0, 0, 0, 9999, 1, 1, 2'b01);
    rep(3, 0, 0, 0, 9999, 0, 1, 2'b01);
    add(0, 0, 0, 0, 1, 1, 2'b01);
    // Mode toggled mid-period; only the level on the wrap edge matters.
    rep(2, 0, 0, 1, 0, 0, 1, 2'b01);
    add(0, 0, 0, 0, 0, 1, 2'b01);
    add(0, 0, 0, 1, 1, 1, 2'b01);
    // Stop mid-period, clear alone, resume: full period from a zeroed divider.
    add(1, 0, 0, 1, 0, 0, 2'b00);
    add(0, 1, 0, 1, 0, 0, 2'b10);
    add(0, 0, 0, 0, 0, 0, 2'b00);
    add(1, 0, 0, 0, 0, 1, 2'b01);
    rep(3, 0, 0, 0, 0, 0, 1, 2'b01);
    add(0, 0, 0, 1, 1, 1, 2'b01);

    reset        = 1'b1;
    btn_run_stop = 1'b1;
    btn_clear    = 1'b0;
    sw_mode      = 1'b0;
    #12;
    check_now("reset_state", 0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    btn_run_stop = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_now("after_release", 0, 1'b0, 1'b0, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      step("vec", vecs[i], i);
    end

    // Async reset between edges while a tick is being shown.
    #2;
    reset = 1'b1;
    #1;
    check_now("async_reset", 0, 1'b0, 1'b0, 2'b00);
    @(posedge clk);
    #1;
    check_now("reset_held", 0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    idle.rs = 1'b0; idle.clr = 1'b0; idle.mode = 1'b0;
    idle.count = 0; idle.tick = 1'b0; idle.run = 1'b0; idle.state = 2'b00;
    for (int i = 0; i < 8; i++) begin
      step("post_reset_idle", idle, i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
